// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_refill_ctrl
//  Purpose  : Cache miss handler: dirty-victim write-back, then word-by-word
//             line fetch streamed into the cache fill port.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int IW            = $clog2(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_req_i,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  victim_dirty_i,
    input  logic [ADDR_WIDTH-1:0] victim_addr_i,
    input  logic [DATA_WIDTH-1:0] victim_data_i,
    output logic [IW-1:0]         victim_idx_o,
    output logic                  fill_we_o,
    output logic [IW-1:0]         fill_idx_o,
    output logic [DATA_WIDTH-1:0] fill_data_o,
    output logic                  miss_done_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ready_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int                    OFS       = IW + 2;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1));
    localparam logic [IW-1:0]         LAST_K    = IW'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_FREQ  = 3'd2,
        S_FWAIT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q,       state_d;
    logic [IW-1:0]         k_q,           k_d;
    logic [ADDR_WIDTH-1:0] line_base_q,   line_base_d;
    logic [ADDR_WIDTH-1:0] victim_base_q, victim_base_d;
    logic                  fill_we_q,     fill_we_d;
    logic [IW-1:0]         fill_idx_q,    fill_idx_d;
    logic [DATA_WIDTH-1:0] fill_data_q,   fill_data_d;
    logic [ADDR_WIDTH-1:0] word_ofs;

    // Bases are line aligned, so OR-ing in the word offset never carries.
    assign word_ofs = {{(ADDR_WIDTH-OFS){1'b0}}, k_q, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            line_base_q   <= '0;
            victim_base_q <= '0;
            fill_we_q     <= 1'b0;
            fill_idx_q    <= '0;
            fill_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            line_base_q   <= line_base_d;
            victim_base_q <= victim_base_d;
            fill_we_q     <= fill_we_d;
            fill_idx_q    <= fill_idx_d;
            fill_data_q   <= fill_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        line_base_d   = line_base_q;
        victim_base_d = victim_base_q;
        fill_we_d     = 1'b0;
        fill_idx_d    = fill_idx_q;
        fill_data_d   = fill_data_q;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        victim_idx_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (miss_req_i) begin
                    line_base_d   = miss_addr_i & LINE_MASK;
                    victim_base_d = victim_addr_i & LINE_MASK;
                    k_d           = '0;
                    state_d       = victim_dirty_i ? S_WB : S_FREQ;
                end
            end
            S_WB: begin
                mem_req_o    = 1'b1;
                mem_we_o     = 1'b1;
                mem_addr_o   = victim_base_q | word_ofs;
                mem_wdata_o  = victim_data_i;
                victim_idx_o = k_q;
                if (mem_ready_i) begin
                    if (k_q == LAST_K) begin
                        k_d     = '0;
                        state_d = S_FREQ;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end
            S_FREQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = line_base_q | word_ofs;
                if (mem_ready_i) begin
                    state_d = S_FWAIT;
                end
            end
            S_FWAIT: begin
                // Fill port is registered: the write lands one cycle after rvalid.
                if (mem_rvalid_i) begin
                    fill_we_d   = 1'b1;
                    fill_idx_d  = k_q;
                    fill_data_d = mem_rdata_i;
                    if (k_q == LAST_K) begin
                        k_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + IW'(1);
                        state_d = S_FREQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fill_we_o   = fill_we_q;
    assign fill_idx_o  = fill_idx_q;
    assign fill_data_o = fill_data_q;
    assign miss_done_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_refill_ctrl
//  Purpose  : Directed self-checking bench for cache_refill_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_req_i;
    logic [AW-1:0] miss_addr_i;
    logic          victim_dirty_i;
    logic [AW-1:0] victim_addr_i;
    logic [DW-1:0] victim_data_i;
    logic [IW-1:0] victim_idx_o;
    logic          fill_we_o;
    logic [IW-1:0] fill_idx_o;
    logic [DW-1:0] fill_data_o;
    logic          miss_done_o;
    logic          busy_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ready_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    cache_refill_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_req_i    (miss_req_i),
        .miss_addr_i   (miss_addr_i),
        .victim_dirty_i(victim_dirty_i),
        .victim_addr_i (victim_addr_i),
        .victim_data_i (victim_data_i),
        .victim_idx_o  (victim_idx_o),
        .fill_we_o     (fill_we_o),
        .fill_idx_o    (fill_idx_o),
        .fill_data_o   (fill_data_o),
        .miss_done_o   (miss_done_o),
        .busy_o        (busy_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Cache victim line: word i reads as 0xBEEF_0000 + i.
    assign victim_data_i = 32'hBEEF_0000 | 32'(victim_idx_o);

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          t0     = 0;
    logic        stall_en   = 1'b0;
    int          stall_from = 0;
    int          stall_len  = 0;
    logic        spur_idle  = 1'b0;
    logic [31:0] spur_mask  = '0;
    logic [31:0] busy_mask;
    int          stall_cycles;
    int          stable_err;
    logic        in_stall;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;
    logic          snap_we;

    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wa_log[$];
    logic [DW-1:0] wd_log[$];
    logic [IW-1:0] fi_log[$];
    logic [DW-1:0] fd_log[$];
    int            fr_log[$];
    int            done_log[$];

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ready unless stalled, read data one cycle after a read handshake.
    initial begin : responder
        logic          hs_pend;
        logic [AW-1:0] hs_addr;
        int            rel;
        hs_pend      = 1'b0;
        hs_addr      = '0;
        mem_ready_i  = 1'b1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #3;
            rel          = cyc - t0;
            mem_ready_i  = !(stall_en && rel >= stall_from && rel < stall_from + stall_len);
            mem_rvalid_i = hs_pend || spur_idle || (rel >= 0 && rel < 32 && spur_mask[rel]);
            mem_rdata_i  = hs_pend ? mdata(hs_addr) : 32'hDEAD_BEEF;
            @(negedge clk);
            hs_pend = mem_req_o && mem_ready_i && !mem_we_o;
            hs_addr = mem_addr_o;
        end
    end

    initial begin : monitor
        int rel;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (mem_req_o && mem_ready_i) begin
                if (mem_we_o) begin
                    wa_log.push_back(mem_addr_o);
                    wd_log.push_back(mem_wdata_o);
                end else begin
                    rd_log.push_back(mem_addr_o);
                end
            end
            if (fill_we_o) begin
                fi_log.push_back(fill_idx_o);
                fd_log.push_back(fill_data_o);
                fr_log.push_back(rel);
            end
            if (miss_done_o) done_log.push_back(rel);
            if (rel >= 0 && rel < 32) busy_mask[rel] = busy_o;
            if (mem_req_o && !mem_ready_i) begin
                if (!in_stall) begin
                    snap_addr  = mem_addr_o;
                    snap_wdata = mem_wdata_o;
                    snap_we    = mem_we_o;
                    in_stall   = 1'b1;
                end else if (mem_addr_o !== snap_addr || mem_wdata_o !== snap_wdata || mem_we_o !== snap_we) begin
                    stable_err++;
                end
                stall_cycles++;
            end else begin
                in_stall = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    task automatic start_miss(input logic [AW-1:0] addr, input logic dirty, input logic [AW-1:0] vaddr);
        @(posedge clk);
        #1;
        miss_addr_i    = addr;
        victim_dirty_i = dirty;
        victim_addr_i  = vaddr;
        miss_req_i     = 1'b1;
        t0             = cyc;
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        fi_log.delete(); fd_log.delete(); fr_log.delete(); done_log.delete();
        busy_mask    = '0;
        stall_cycles = 0;
        stable_err   = 0;
        in_stall     = 1'b0;
    endtask

    // Holds miss_req until ndone pulses are seen; optionally perturbs miss_addr mid-refill.
    task automatic wait_done(input int ndone, input int chg_at, input logic [AW-1:0] chg_addr);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (cyc - t0 == chg_at) miss_addr_i = chg_addr;
            if (done_log.size() >= ndone) break;
        end
        miss_req_i = 1'b0;
        checks++;
        if (done_log.size() < ndone) begin
            errors++;
            $display("FAIL wait_done: saw %0d miss_done pulses, required %0d", done_log.size(), ndone);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        miss_req_i     = 1'b0;
        miss_addr_i    = '0;
        victim_dirty_i = 1'b0;
        victim_addr_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_req_o, mem_we_o, fill_we_o, miss_done_o, busy_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/fill_we/done/busy = %b, required 00000",
                     {mem_req_o, mem_we_o, fill_we_o, miss_done_o, busy_o});
        end
        checks++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0 || fill_data_o !== '0 || fill_idx_o !== '0 || victim_idx_o !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h fdata=%h fidx=%0d vidx=%0d, required all 0",
                     mem_addr_o, mem_wdata_o, fill_data_o, fill_idx_o, victim_idx_o);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_miss: busy=%b mem_req=%b, required 0 0", busy_o, mem_req_o);
        end
    endtask

    task automatic test_clean_miss();
        start_miss(32'h0000_1234, 1'b0, 32'h0);
        wait_done(1, -1, '0);
        checks++;
        if (rd_log.size() != 4 || wa_log.size() != 0) begin
            errors++;
            $display("FAIL clean_counts: reads=%0d writes=%0d, required 4 0", rd_log.size(), wa_log.size());
        end
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 32'h1230 + 32'(4*i)) begin
                errors++;
                $display("FAIL clean_raddr[%0d]: got %h, required %h", i, rd_log[i], 32'h1230 + 32'(4*i));
            end
        end
        checks++;
        if (fi_log.size() != 4) begin
            errors++;
            $display("FAIL clean_fills: got %0d fill writes, required 4", fi_log.size());
        end
        for (int i = 0; i < 4 && i < fi_log.size(); i++) begin
            checks++;
            if (fi_log[i] !== 2'(i) || fd_log[i] !== mdata(32'h1230 + 32'(4*i))) begin
                errors++;
                $display("FAIL clean_fill[%0d]: idx=%0d data=%h, required idx=%0d data=%h",
                         i, fi_log[i], fd_log[i], i, mdata(32'h1230 + 32'(4*i)));
            end
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] != 9) begin
            errors++;
            $display("FAIL clean_done_cycle: pulses=%0d first_at=%0d, required 1 at 9",
                     done_log.size(), done_log.size() > 0 ? done_log[0] : -1);
        end
        checks++;
        if (fr_log.size() != 4 || fr_log[3] != 9) begin
            errors++;
            $display("FAIL clean_last_fill_cycle: got %0d, required 9", fr_log.size() == 4 ? fr_log[3] : -1);
        end
        checks++;
        if (busy_mask[12:0] !== 13'h03FE) begin
            errors++;
            $display("FAIL clean_busy: cycles 0..12 busy=%b, required %b", busy_mask[12:0], 13'h03FE);
        end
    endtask

    task automatic test_dirty_miss();
        start_miss(32'h0000_0040, 1'b1, 32'h0000_8010);
        wait_done(1, -1, '0);
        checks++;
        if (wa_log.size() != 4 || rd_log.size() != 4) begin
            errors++;
            $display("FAIL dirty_counts: writes=%0d reads=%0d, required 4 4", wa_log.size(), rd_log.size());
        end
        for (int i = 0; i < 4 && i < wa_log.size(); i++) begin
            checks++;
            if (wa_log[i] !== 32'h8010 + 32'(4*i) || wd_log[i] !== 32'hBEEF_0000 + 32'(i)) begin
                errors++;
                $display("FAIL dirty_write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         i, wa_log[i], wd_log[i], 32'h8010 + 32'(4*i), 32'hBEEF_0000 + 32'(i));
            end
        end
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 32'h40 + 32'(4*i)) begin
                errors++;
                $display("FAIL dirty_raddr[%0d]: got %h, required %h", i, rd_log[i], 32'h40 + 32'(4*i));
            end
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] != 13) begin
            errors++;
            $display("FAIL dirty_done_cycle: pulses=%0d first_at=%0d, required 1 at 13",
                     done_log.size(), done_log.size() > 0 ? done_log[0] : -1);
        end
    endtask

    task automatic test_ready_stall();
        start_miss(32'h0000_0588, 1'b1, 32'h0000_9F20);
        stall_en   = 1'b1;
        stall_from = 2;
        stall_len  = 3;
        wait_done(1, -1, '0);
        stall_en = 1'b0;
        checks++;
        if (stall_cycles != 3 || stable_err != 0) begin
            errors++;
            $display("FAIL stall_hold: stalled=%0d unstable=%0d, required 3 0", stall_cycles, stable_err);
        end
        checks++;
        if (wa_log.size() != 4 || fi_log.size() != 4) begin
            errors++;
            $display("FAIL stall_counts: writes=%0d fills=%0d, required 4 4", wa_log.size(), fi_log.size());
        end
        for (int i = 0; i < 4 && i < wa_log.size(); i++) begin
            checks++;
            if (wa_log[i] !== 32'h9F20 + 32'(4*i) || wd_log[i] !== 32'hBEEF_0000 + 32'(i)) begin
                errors++;
                $display("FAIL stall_write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         i, wa_log[i], wd_log[i], 32'h9F20 + 32'(4*i), 32'hBEEF_0000 + 32'(i));
            end
        end
        for (int i = 0; i < 4 && i < fd_log.size(); i++) begin
            checks++;
            if (fd_log[i] !== mdata(32'h0580 + 32'(4*i))) begin
                errors++;
                $display("FAIL stall_fill[%0d]: got %h, required %h", i, fd_log[i], mdata(32'h0580 + 32'(4*i)));
            end
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] != 16) begin
            errors++;
            $display("FAIL stall_done_cycle: pulses=%0d first_at=%0d, required 1 at 16",
                     done_log.size(), done_log.size() > 0 ? done_log[0] : -1);
        end
    endtask

    task automatic test_reset_mid_refill();
        start_miss(32'h0000_2008, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc - t0 == 6) break;
        end
        checks++;
        if (busy_o !== 1'b1 || fill_idx_o !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre: busy=%b fill_idx=%0d, required 1 1", busy_o, fill_idx_o);
        end
        rst_n      = 1'b0;
        miss_req_i = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, fill_we_o, busy_o, miss_done_o} !== 4'b0 || fill_idx_o !== '0 || fill_data_o !== '0) begin
            errors++;
            $display("FAIL rst_async: req/fill_we/busy/done=%b idx=%0d data=%h, required 0000 0 0",
                     {mem_req_o, fill_we_o, busy_o, miss_done_o}, fill_idx_o, fill_data_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_miss(32'h0000_3004, 1'b0, 32'h0);
        wait_done(1, -1, '0);
        checks++;
        if (rd_log.size() != 4 || fi_log.size() != 4) begin
            errors++;
            $display("FAIL rst_restart_counts: reads=%0d fills=%0d, required 4 4", rd_log.size(), fi_log.size());
        end
        for (int i = 0; i < 4 && i < rd_log.size() && i < fi_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 32'h3000 + 32'(4*i) || fi_log[i] !== 2'(i)) begin
                errors++;
                $display("FAIL rst_restart[%0d]: addr=%h idx=%0d, required addr=%h idx=%0d",
                         i, rd_log[i], fi_log[i], 32'h3000 + 32'(4*i), i);
            end
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] != 9) begin
            errors++;
            $display("FAIL rst_restart_done: pulses=%0d first_at=%0d, required 1 at 9",
                     done_log.size(), done_log.size() > 0 ? done_log[0] : -1);
        end
    endtask

    task automatic test_spurious();
        int n0;
        n0        = fi_log.size();
        spur_idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        spur_idle = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (fi_log.size() != n0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle: new fills=%0d busy=%b, required 0 0", fi_log.size() - n0, busy_o);
        end
        start_miss(32'h0000_7718, 1'b0, 32'h0);
        spur_mask = 32'b1011;
        wait_done(1, 4, 32'hFFFF_FF00);
        spur_mask = '0;
        checks++;
        if (rd_log.size() != 4 || fi_log.size() != 4) begin
            errors++;
            $display("FAIL spur_counts: reads=%0d fills=%0d, required 4 4", rd_log.size(), fi_log.size());
        end
        for (int i = 0; i < 4 && i < rd_log.size() && i < fd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 32'h7710 + 32'(4*i) || fd_log[i] !== mdata(32'h7710 + 32'(4*i))) begin
                errors++;
                $display("FAIL spur_word[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         i, rd_log[i], fd_log[i], 32'h7710 + 32'(4*i), mdata(32'h7710 + 32'(4*i)));
            end
        end
        checks++;
        if (done_log.size() != 1 || done_log[0] != 9) begin
            errors++;
            $display("FAIL spur_done: pulses=%0d first_at=%0d, required 1 at 9",
                     done_log.size(), done_log.size() > 0 ? done_log[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        start_miss(32'h0000_A000, 1'b0, 32'h0);
        wait_done(2, 5, 32'h0000_B0F4);
        checks++;
        if (done_log.size() != 2 || done_log[0] != 9 || done_log[1] != 19) begin
            errors++;
            $display("FAIL b2b_done: pulses=%0d, required 2 at cycles 9 and 19", done_log.size());
        end
        checks++;
        if (rd_log.size() != 8 || fi_log.size() != 8) begin
            errors++;
            $display("FAIL b2b_counts: reads=%0d fills=%0d, required 8 8", rd_log.size(), fi_log.size());
        end
        for (int i = 0; i < 8 && i < rd_log.size() && i < fd_log.size(); i++) begin
            logic [AW-1:0] ea;
            ea = (i < 4) ? 32'hA000 + 32'(4*i) : 32'hB0F0 + 32'(4*(i-4));
            checks++;
            if (rd_log[i] !== ea || fd_log[i] !== mdata(ea)) begin
                errors++;
                $display("FAIL b2b_word[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         i, rd_log[i], fd_log[i], ea, mdata(ea));
            end
        end
        checks++;
        if (busy_mask[22:0] !== 23'h0F_FBFE) begin
            errors++;
            $display("FAIL b2b_busy: cycles 0..22 busy=%b, required %b", busy_mask[22:0], 23'h0F_FBFE);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_ready_stall();
        test_reset_mid_refill();
        test_spurious();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
